ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter_pkg.sv | 26 ++
 rtl/ram_port_arbiter_arb_pick.sv | 37 +++
 rtl/ram_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
// Shared definitions for the two-port RAM arbiter: FSM state encoding,
// requester identifiers, bus widths and a small helper for the arbiter.
// No ports (package).
package ram_port_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } req_id_t;

    // The requester that is not the given one.
    function automatic req_id_t other_id(input req_id_t id);
        other_id = (id == DATA) ? FETCH : DATA;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_arb_pick.sv
// arb_pick
// Combinational two-way picker between the fetch and data requesters.
// Ports:
//   if_req, d_req  : request lines of fetch / data
//   rr_mode        : 1 = on a tie pick the requester that did not win last
//                    time, 0 = on a tie data wins
//   last_winner    : previous winner (only meaningful when rr_mode=1)
//   any_req        : at least one request present
//   winner         : selected requester (FETCH when no request)
module arb_pick
    import ram_port_arbiter_pkg::*;
(
    input  logic    if_req,
    input  logic    d_req,
    input  logic    rr_mode,
    input  req_id_t last_winner,
    output logic    any_req,
    output req_id_t winner
);

    // Pick a winner; a lone request always wins.
    always_comb begin
        any_req = if_req | d_req;
        if (if_req && d_req) begin
            if (rr_mode) begin
                winner = other_id(last_winner);
            end else begin
                winner = DATA;
            end
        end else if (d_req) begin
            winner = DATA;
        end else begin
            winner = FETCH;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port synchronous RAM between an instruction-fetch port
// (read only) and a data port (read/write). One access takes ACCESS (RAM
// strobe + grant) followed by RESP (read data returned), so a continuously
// busy RAM serves one access every two cycles.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate winners on a tie;
// otherwise data has fixed priority on a tie.
// Ports:
//   clk, rst                       : clock (rising edge), async active-low reset
//   if_req/if_addr                 : fetch request and word address
//   if_gnt/if_rvalid/if_rdata      : fetch grant pulse, data valid pulse, data
//   d_req/d_we/d_addr/d_wdata      : data request, write enable, address, data
//   d_gnt/d_rvalid/d_rdata         : data grant pulse, read valid pulse, data
//   ram_en/ram_we/ram_addr/ram_wdata : RAM strobe, write, address, write data
//   ram_rdata                      : RAM read data, valid the cycle after ram_en
//   busy                           : FSM not in IDLE
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    state_t            state_r, next_state_s;
    req_id_t           lat_id_r, next_id_s;
    logic              lat_we_r, next_we_s;
    logic [ADDR_W-1:0] lat_addr_r, next_addr_s;
    logic [DATA_W-1:0] lat_wdata_r, next_wdata_s;
    logic              any_req_s;
    req_id_t           pick_s;
    req_id_t           last_winner_s;
    logic              rr_mode_s;
    logic              if_gnt_r, d_gnt_r, if_rvalid_r, d_rvalid_r;
    logic              ram_en_r, ram_we_r, busy_r;
    logic [DATA_W-1:0] if_rdata_r, d_rdata_r;

`ifdef ARB_ROUND_ROBIN_EN
    req_id_t last_winner_r;

    assign rr_mode_s     = 1'b1;
    assign last_winner_s = last_winner_r;

    // Remember who won the most recent grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_winner_r <= DATA;
        end else if (next_state_s == ACCESS) begin
            last_winner_r <= next_id_s;
        end else begin
            last_winner_r <= last_winner_r;
        end
    end
`else
    assign rr_mode_s     = 1'b0;
    assign last_winner_s = DATA;
`endif

    arb_pick u_arb_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .rr_mode     (rr_mode_s),
        .last_winner (last_winner_s),
        .any_req     (any_req_s),
        .winner      (pick_s)
    );

    // Next state and the request fields latched at arbitration time.
    always_comb begin
        next_state_s = state_r;
        next_id_s    = lat_id_r;
        next_we_s    = lat_we_r;
        next_addr_s  = lat_addr_r;
        next_wdata_s = lat_wdata_r;
        case (state_r)
            IDLE, RESP: begin
                if (any_req_s) begin
                    next_state_s = ACCESS;
                    next_id_s    = pick_s;
                    if (pick_s == DATA) begin
                        next_we_s    = d_we;
                        next_addr_s  = d_addr;
                        next_wdata_s = d_wdata;
                    end else begin
                        next_we_s    = 1'b0;
                        next_addr_s  = if_addr;
                        next_wdata_s = {DATA_W{1'b0}};
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCESS: begin
                next_state_s = RESP;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State and latched request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            lat_id_r    <= DATA;
            lat_we_r    <= 1'b0;
            lat_addr_r  <= {ADDR_W{1'b0}};
            lat_wdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r     <= next_state_s;
            lat_id_r    <= next_id_s;
            lat_we_r    <= next_we_s;
            lat_addr_r  <= next_addr_s;
            lat_wdata_r <= next_wdata_s;
        end
    end

    // Output strobes are decoded from the next state so they are flops
    // that line up with the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_gnt_r    <= 1'b0;
            d_gnt_r     <= 1'b0;
            ram_en_r    <= 1'b0;
            ram_we_r    <= 1'b0;
            if_rvalid_r <= 1'b0;
            d_rvalid_r  <= 1'b0;
            busy_r      <= 1'b0;
            if_rdata_r  <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
        end else begin
            if_gnt_r    <= (next_state_s == ACCESS) && (next_id_s == FETCH);
            d_gnt_r     <= (next_state_s == ACCESS) && (next_id_s == DATA);
            ram_en_r    <= (next_state_s == ACCESS);
            ram_we_r    <= (next_state_s == ACCESS) && next_we_s;
            if_rvalid_r <= (next_state_s == RESP) && !next_we_s && (next_id_s == FETCH);
            d_rvalid_r  <= (next_state_s == RESP) && !next_we_s && (next_id_s == DATA);
            busy_r      <= (next_state_s != IDLE);
            // Keep the returned word so rdata holds once rvalid drops.
            if (if_rvalid_r) begin
                if_rdata_r <= ram_rdata;
            end else begin
                if_rdata_r <= if_rdata_r;
            end
            if (d_rvalid_r) begin
                d_rdata_r <= ram_rdata;
            end else begin
                d_rdata_r <= d_rdata_r;
            end
        end
    end

    assign if_gnt    = if_gnt_r;
    assign d_gnt     = d_gnt_r;
    assign ram_en    = ram_en_r;
    assign ram_we    = ram_we_r;
    assign ram_addr  = lat_addr_r;
    assign ram_wdata = lat_wdata_r;
    assign if_rvalid = if_rvalid_r;
    assign d_rvalid  = d_rvalid_r;
    assign busy      = busy_r;
    // RAM data arrives during RESP; pass it straight through in that cycle.
    assign if_rdata  = if_rvalid_r ? ram_rdata : if_rdata_r;
    assign d_rdata   = d_rvalid_r  ? ram_rdata : d_rdata_r;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Self-checking bench for ram_port_arbiter with a behavioural RAM, a vector
// table of single accesses, a read-data scoreboard and hand-written
// sequences for ties, back-to-back access, reset mid-access and idle.
// Honours ARB_ROUND_ROBIN_EN for the tie expectations.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = 16'h0000;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = 16'h0000;
    logic [31:0] d_wdata = 32'h0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic        busy;

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    function automatic logic [31:0] init_word(input int i);
        init_word = (i == 4) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(i));
    endfunction

    // Behavioural synchronous RAM (64 words, low address bits only).
    logic [31:0] mem [0:63];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr[5:0]] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr[5:0]];
        end
    end

    // Expected RAM contents, updated when write stimulus is issued.
    logic [31:0] shadow [0:63];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    typedef struct {
        logic        is_data;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [31:0] last_if = 32'h0;
    logic [31:0] last_d  = 32'h0;

    // Scoreboard monitor: every rvalid must match the oldest expected read.
    always @(negedge clk) begin
        if (!rst) begin
            last_if = 32'h0;
            last_d  = 32'h0;
        end
        if (if_rvalid || d_rvalid) begin
            if (if_rvalid && d_rvalid) begin
                chk("rvalid_both", 32'({if_rvalid, d_rvalid}), 32'd1);
            end else if (sb.size() == 0) begin
                chk("rvalid_unexpected", 32'({if_rvalid, d_rvalid}), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rvalid_port", 32'(d_rvalid), 32'(e.is_data));
                chk("rdata", e.is_data ? d_rdata : if_rdata, e.data);
                if (e.is_data) last_d = e.data;
                else           last_if = e.data;
            end
        end
    end

    typedef struct {
        logic        is_data;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } vec_t;
    vec_t vecs [0:6];

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        if (v.is_data) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        if (!v.we) sb.push_back('{v.is_data, shadow[v.addr[5:0]]});
        else       shadow[v.addr[5:0]] = v.wdata;
        @(posedge clk); @(negedge clk);
        chk("gnt_if", 32'(if_gnt), 32'(!v.is_data));
        chk("gnt_d", 32'(d_gnt), 32'(v.is_data));
        chk("ram_en", 32'(ram_en), 32'd1);
        chk("ram_we", 32'(ram_we), 32'(v.we));
        chk("ram_addr", 32'(ram_addr), 32'(v.addr));
        if (v.we) chk("ram_wdata", ram_wdata, v.wdata);
        if_req = 1'b0; d_req = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("resp_ram_en", 32'(ram_en), 32'd0);
        chk("resp_busy", 32'(busy), 32'd1);
        if (v.we) chk("wr_no_rvalid", 32'({if_rvalid, d_rvalid}), 32'd0);
    endtask

    initial begin
        logic exp_data;
        for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
        vecs[0] = '{1'b0, 1'b0, 16'h0004, 32'h00000000};
        vecs[1] = '{1'b1, 1'b1, 16'h0100, 32'h12345678};
        vecs[2] = '{1'b1, 1'b0, 16'h0100, 32'h00000000};
        vecs[3] = '{1'b0, 1'b0, 16'h0000, 32'h00000000};
        vecs[4] = '{1'b1, 1'b1, 16'h0007, 32'hCAFEF00D};
        vecs[5] = '{1'b0, 1'b0, 16'h0007, 32'h00000000};
        vecs[6] = '{1'b1, 1'b0, 16'h0004, 32'h00000000};

        // Reset state
        @(negedge clk);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt", 32'({if_gnt, d_gnt}), 32'd0);
        chk("rst_rvalid", 32'({if_rvalid, d_rvalid}), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Tie with both requests held for four grants
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0001;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0002;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_data = (k % 2) != 0;
`else
            exp_data = 1'b1;
`endif
            @(posedge clk); @(negedge clk);
            chk("tie_gnt_if", 32'(if_gnt), 32'(!exp_data));
            chk("tie_gnt_d", 32'(d_gnt), 32'(exp_data));
            chk("tie_ram_addr", 32'(ram_addr), exp_data ? 32'd2 : 32'd1);
            sb.push_back('{exp_data, exp_data ? shadow[2] : shadow[1]});
            if (k == 3) begin
                if_req = 1'b0; d_req = 1'b0;
            end
            @(posedge clk);
        end

        // Back-to-back: fetch raised during the data RESP cycle
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0003;
        sb.push_back('{1'b1, shadow[3]});
        @(posedge clk); @(negedge clk);
        chk("b2b_c1_ram_en", 32'(ram_en), 32'd1);
        chk("b2b_c1_d_gnt", 32'(d_gnt), 32'd1);
        d_req = 1'b0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0005;
        sb.push_back('{1'b0, shadow[5]});
        @(negedge clk);
        chk("b2b_c2_ram_en", 32'(ram_en), 32'd0);
        chk("b2b_c2_busy", 32'(busy), 32'd1);
        @(posedge clk); @(negedge clk);
        chk("b2b_c3_ram_en", 32'(ram_en), 32'd1);
        chk("b2b_c3_if_gnt", 32'(if_gnt), 32'd1);
        chk("b2b_c3_busy", 32'(busy), 32'd1);
        if_req = 1'b0;
        @(posedge clk); @(negedge clk);
        @(negedge clk);
        chk("hold_if_rdata", if_rdata, shadow[5]);
        chk("hold_d_rdata", d_rdata, shadow[3]);

        // Reset asserted during ACCESS
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0006;
        @(posedge clk); #2;
        chk("prerst_ram_en", 32'(ram_en), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_ram_en", 32'(ram_en), 32'd0);
        chk("arst_ram_we", 32'(ram_we), 32'd0);
        chk("arst_gnt", 32'({if_gnt, d_gnt}), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ram_addr", 32'(ram_addr), 32'd0);
        chk("arst_ram_wdata", ram_wdata, 32'd0);
        chk("arst_if_rdata", if_rdata, 32'd0);
        chk("arst_d_rdata", d_rdata, 32'd0);
        if_req = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_rvalid", 32'({if_rvalid, d_rvalid}), 32'd0);
            chk("postrst_busy", 32'(busy), 32'd0);
        end

        // Idle for ten cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ram_en", 32'(ram_en), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
